// File: rtl/nes_controller_emulator.sv
// -----------------------------------------------------------------------------
// nes_controller_emulator
//
// Device-side NES gamepad emulator. Answers the console's latch/clock strobes
// and serially presents eight button states on the data line, so the host-side
// reader (or a real console) can be driven from FPGA-internal state.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth on each strobe input (minimum 2)
//   ACTIVE_LOW   1: pressed button drives dataYellow low (real NES level)
//                0: pressed button drives dataYellow high
//
// Ports:
//   clock        system clock, all state updates on rising edge
//   reset        asynchronous, active-high reset
//   latchOrange  latch strobe from host (asynchronous to clock)
//   clockRed     shift clock from host (asynchronous to clock)
//   buttons[7:0] 1 = pressed, {a, b, select, start, up, down, left, right}
//   dataYellow   serial data to host (registered)
//   frameDone    one-cycle pulse when the last bit (right) is placed on the wire
//   busy         high while in LOAD or SHIFT
// -----------------------------------------------------------------------------
module nes_controller_emulator #(
  parameter int SYNC_STAGES = 2,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       latchOrange,
  input  logic       clockRed,
  input  logic [7:0] buttons,
  output logic       dataYellow,
  output logic       frameDone,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    SHIFT     = 2'd2,
    EXHAUSTED = 2'd3
  } state_t;

  // Strobe synchronizers plus one flop of history for edge detection
  logic [SYNC_STAGES-1:0] r_latch_sync;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic                   r_latch_d;
  logic                   r_clk_d;

  logic w_latch_s;
  logic w_clk_s;
  logic w_latch_fall;
  logic w_clk_rise;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_latch_sync <= '0;
      r_clk_sync   <= '0;
      r_latch_d    <= 1'b0;
      r_clk_d      <= 1'b0;
    end else begin
      r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], latchOrange};
      r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], clockRed};
      r_latch_d    <= w_latch_s;
      r_clk_d      <= w_clk_s;
    end
  end

  assign w_latch_s    = r_latch_sync[SYNC_STAGES-1];
  assign w_clk_s      = r_clk_sync[SYNC_STAGES-1];
  assign w_latch_fall = ~w_latch_s & r_latch_d;
  assign w_clk_rise   = w_clk_s & ~r_clk_d;

  // Buttons translated to the level they must produce on the wire
  logic [7:0] w_wire;
  assign w_wire = ACTIVE_LOW ? ~buttons : buttons;

  // Frame FSM
  state_t     r_state;
  state_t     w_state_nx;
  logic [7:0] r_shreg;
  logic [7:0] w_shreg_nx;
  logic [2:0] r_bit_idx;
  logic [2:0] w_bit_idx_nx;
  logic       r_done;
  logic       w_done_nx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shreg   <= 8'hFF;
      r_bit_idx <= 3'd0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_shreg   <= w_shreg_nx;
      r_bit_idx <= w_bit_idx_nx;
      r_done    <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_shreg_nx   = r_shreg;
    w_bit_idx_nx = r_bit_idx;
    w_done_nx    = 1'b0;

    // An active latch overrides everything: it aborts any frame in progress
    // and suppresses a coincident shift clock.
    if (w_latch_s) begin
      w_state_nx   = LOAD;
      w_shreg_nx   = w_wire;
      w_bit_idx_nx = 3'd0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_latch_fall) begin
            w_state_nx   = SHIFT;
            w_bit_idx_nx = 3'd0;
          end
        end
        SHIFT: begin
          if (w_clk_rise) begin
            w_shreg_nx   = {r_shreg[6:0], 1'b1};
            w_bit_idx_nx = r_bit_idx + 3'd1;
            // Index 6 -> 7 places 'right' on the wire: frame complete
            if (r_bit_idx == 3'd6) begin
              w_state_nx = EXHAUSTED;
              w_done_nx  = 1'b1;
            end
          end
        end
        EXHAUSTED: begin
          // Keep shifting in ones so an over-clocked read sees 1s;
          // the bit index stays saturated at 7.
          if (w_clk_rise) begin
            w_shreg_nx = {r_shreg[6:0], 1'b1};
          end
        end
        default: begin
          // IDLE ignores shift clocks
        end
      endcase
    end
  end

  assign dataYellow = r_shreg[7];
  assign frameDone  = r_done;
  assign busy       = (r_state == LOAD) || (r_state == SHIFT);

endmodule
